// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: playfield geometry,
// coordinate widths and the food placer state encoding.
package snake_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;
    localparam int X_W    = 6;
    localparam int Y_W    = 5;
    localparam int RAND_W = 14;
    localparam int TRY_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_RAND = 3'd2,
        ST_CHECK     = 3'd3,
        ST_QUERY     = 3'd4,
        ST_WAIT_OCC  = 3'd5,
        ST_DONE      = 3'd6,
        ST_FAIL      = 3'd7
    } place_state_t;

    // Increment that sticks at all-ones instead of wrapping back to zero.
    function automatic logic [TRY_W-1:0] sat_inc(input logic [TRY_W-1:0] value);
        return (value == {TRY_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/food_placer.sv
// Food placer: draws random cells until one is on the playfield and not
// covered by the snake, then publishes it as the new food position.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for a placement request
// REQ        | one-cycle request to the random source, counts a try
// WAIT_RAND  | waiting for a nonzero random word, latches the candidate
// CHECK      | rejects candidates outside the playfield
// QUERY      | one-cycle occupancy query for the candidate cell
// WAIT_OCC   | waiting for the occupancy answer
// DONE       | food position updated, valid pulse
// FAIL       | tries exhausted, fail pulse, food position unchanged
module food_placer
    import snake_pkg::*;
#(
    parameter int MAX_TRIES = 16
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Place,
    output logic              o_RandNeed,
    input  logic [RAND_W-1:0] i_RandNum,
    output logic              o_OccQuery,
    output logic [X_W-1:0]    o_OccX,
    output logic [Y_W-1:0]    o_OccY,
    input  logic              i_OccValid,
    input  logic              i_OccHit,
    output logic [X_W-1:0]    o_FoodX,
    output logic [Y_W-1:0]    o_FoodY,
    output logic              o_FoodValid,
    output logic              o_Busy,
    output logic              o_Fail
);

    place_state_t     state;
    place_state_t     state_nxt;
    logic [TRY_W-1:0] try_cnt;
    logic [X_W-1:0]   cand_x;
    logic [Y_W-1:0]   cand_y;
    logic [X_W-1:0]   food_x;
    logic [Y_W-1:0]   food_y;
    logic             rand_valid;
    logic             out_of_range;
    logic             tries_spent;
    logic             occ_free;

    // Compare one bit wider than the coordinates so a full-width grid
    // (64 columns or 32 rows) still fits in the bound.
    assign rand_valid   = (i_RandNum != '0);
    assign out_of_range = ({1'b0, cand_x} >= (X_W+1)'(GRID_W)) ||
                          ({1'b0, cand_y} >= (Y_W+1)'(GRID_H));
    assign tries_spent  = (try_cnt >= TRY_W'(MAX_TRIES));
    assign occ_free     = i_OccValid && !i_OccHit;

    // State register.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and Moore outputs.
    always_comb begin
        state_nxt   = state;
        o_RandNeed  = 1'b0;
        o_OccQuery  = 1'b0;
        o_FoodValid = 1'b0;
        o_Fail      = 1'b0;
        o_Busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                o_Busy = 1'b0;
                if (i_Place) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                o_RandNeed = 1'b1;
                state_nxt  = ST_WAIT_RAND;
            end
            ST_WAIT_RAND: begin
                if (rand_valid) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (out_of_range) begin
                    state_nxt = tries_spent ? ST_FAIL : ST_REQ;
                end else begin
                    state_nxt = ST_QUERY;
                end
            end
            ST_QUERY: begin
                o_OccQuery = 1'b1;
                state_nxt  = ST_WAIT_OCC;
            end
            ST_WAIT_OCC: begin
                if (i_OccValid) begin
                    if (i_OccHit) begin
                        state_nxt = tries_spent ? ST_FAIL : ST_REQ;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                o_FoodValid = 1'b1;
                state_nxt   = ST_IDLE;
            end
            ST_FAIL: begin
                o_Fail    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Try counter: cleared when a placement is accepted, bumped per draw.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            try_cnt <= '0;
        end else if (state == ST_IDLE && i_Place) begin
            try_cnt <= '0;
        end else if (state == ST_REQ) begin
            try_cnt <= sat_inc(try_cnt);
        end
    end

    // Candidate latch; only a word arriving in WAIT_RAND is taken.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            cand_x <= '0;
            cand_y <= '0;
        end else if (state == ST_WAIT_RAND && rand_valid) begin
            cand_x <= i_RandNum[X_W-1:0];
            cand_y <= i_RandNum[X_W+Y_W-1:X_W];
        end
    end

    // Food position loads on the way into DONE so it is already new
    // during the o_FoodValid cycle.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            food_x <= X_W'(GRID_W / 2);
            food_y <= Y_W'(GRID_H / 2);
        end else if (state == ST_WAIT_OCC && occ_free) begin
            food_x <= cand_x;
            food_y <= cand_y;
        end
    end

    assign o_OccX  = cand_x;
    assign o_OccY  = cand_y;
    assign o_FoodX = food_x;
    assign o_FoodY = food_y;

endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 GRID_W, 40, playfield width in cells; legal X is 0..GRID_W-1, with GRID_W <= 64.
REQ-002 GRID_H, 30, playfield height in cells; legal Y is 0..GRID_H-1, with GRID_H <= 32.
REQ-003 MAX_TRIES, 16, maximum random draws per placement before failure; range 1..255.
REQ-004 i_Clk  input  1  single system clock; all logic is on the rising edge.
REQ-005 i_Rst  input  1  reset; one clock; asynchronous, active-low.
REQ-006 i_Place  input  1  one-cycle pulse requesting a new food position; ignored while o_Busy=1.
REQ-007 o_RandNeed  output  1  one-cycle request pulse to the 14-bit random source.
REQ-008 i_RandNum  input  14  random word; nonzero means valid for that cycle, zero means idle.
REQ-009 o_OccQuery  output  1  one-cycle pulse asking the snake body store whether (o_OccX, o_OccY) is occupied.
REQ-010 o_OccX/o_OccY  output  6/5  candidate cell under query, held stable from the query until the response.
REQ-011 i_OccValid  input  1  one-cycle occupancy response strobe, arriving 1..N cycles after o_OccQuery.
REQ-012 i_OccHit  input  1  occupancy result, sampled only when i_OccValid=1; 1 means the cell is occupied.
REQ-013 o_FoodX/o_FoodY  output  6/5  current food cell, held until the next successful placement.
REQ-014 o_FoodValid  output  1  one-cycle pulse when o_FoodX/o_FoodY update.
REQ-015 o_Busy  output  1  high from the cycle after an accepted i_Place until DONE or FAIL completes.
REQ-016 o_Fail  output  1  one-cycle pulse when MAX_TRIES draws are exhausted; o_FoodX/o_FoodY stay unchanged.

Function
REQ-017 FSM states: IDLE, REQ, WAIT_RAND, CHECK, QUERY, WAIT_OCC, DONE, FAIL.
REQ-018 IDLE: i_Place=1 moves to REQ, clears the try counter, and sets o_Busy next cycle.
REQ-019 REQ: assert o_RandNeed for exactly one cycle, increment the try counter, then go to WAIT_RAND.
REQ-020 WAIT_RAND: wait indefinitely for i_RandNum!=0, latch X=i_RandNum[5:0] and Y=i_RandNum[10:6] as the candidate, then go to CHECK.
REQ-021 CHECK: if X>=GRID_W or Y>=GRID_H, reject the candidate, otherwise go to QUERY.
REQ-022 On reject, go to FAIL when try counter==MAX_TRIES, else go to REQ.
REQ-023 QUERY: drive the candidate on o_OccX/o_OccY, pulse o_OccQuery for one cycle, then go to WAIT_OCC.
REQ-024 WAIT_OCC: on i_OccValid with i_OccHit=0, go to DONE.
REQ-025 WAIT_OCC: on i_OccValid with i_OccHit=1, apply the reject rule of REQ-022.
REQ-026 DONE: load o_FoodX/o_FoodY from the candidate, pulse o_FoodValid, clear o_Busy, return to IDLE.
REQ-027 FAIL: pulse o_Fail, clear o_Busy, return to IDLE.
REQ-028 Nonzero i_RandNum outside WAIT_RAND is ignored, and i_OccValid outside WAIT_OCC is ignored.
REQ-029 An i_Place arriving in the same cycle as the DONE or FAIL pulse is ignored; it is accepted only in IDLE.
REQ-030 Minimum latency from i_Place to o_FoodValid is 8 cycles: LFSR returns data 3 cycles after o_RandNeed, and occupancy answers after 1 cycle.
REQ-031 The try counter is 8 bits wide and saturates; it never wraps.

Reset
REQ-032 While i_Rst=0, the FSM is in IDLE, the try counter is 0, the candidate registers are 0, and o_RandNeed, o_OccQuery, o_FoodValid, o_Busy and o_Fail are 0.
REQ-033 o_FoodX resets to GRID_W/2 and o_FoodY resets to GRID_H/2, giving (20,15) with default parameters.
REQ-034 Reset asserted mid-placement aborts the placement immediately, produces no o_FoodValid or o_Fail pulse, and leaves the block in IDLE after release.

Structure
REQ-035 GRID_W, GRID_H, the coordinate widths and the FSM state encoding belong in the shared snake_pkg package.
REQ-036 The block is one flat module with no sub-module; the random source and the occupancy store are external.

Verification
REQ-037 Accept path: i_Place; i_RandNum=0x0A05; OccHit=0 -> one o_FoodValid pulse with (X,Y)=(5,8), o_Busy low afterwards.
REQ-038 Range reject: first i_RandNum=0x002D (X=45) -> no o_OccQuery, a second o_RandNeed follows; then 0x0A05 with OccHit=0 -> food (5,8).
REQ-039 Occupied reject: 0x0A05 with OccHit=1, then 0x0043 with OccHit=0 -> two o_OccQuery pulses, final food (3,1).
REQ-040 Exhaustion: MAX_TRIES=4 with every occupancy answer a hit -> exactly 4 o_RandNeed pulses, one o_Fail, o_FoodX/o_FoodY unchanged at (20,15).
REQ-041 Reset mid-operation: i_Rst low during WAIT_OCC -> all outputs at reset values and no pulses; a new i_Place after release completes normally.
REQ-042 Ignore rules: i_Place while busy, and a stray i_OccValid in WAIT_RAND -> no extra placement and no state corruption.
